// File: rtl/accel_axi_rrarb.sv
// N-master to 1-slave AXI4 arbiter: registered round-robin AR/AW grants, AW-ordered W routing,
// ID-suffix R/B routing, per-master outstanding caps. Optional QoS arbitration: ACCEL_AXI_RRARB_QOS_EN.
package accel_axi_rrarb_pkg;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 64;
  localparam int ID_BITS   = 6;
  localparam int USER_BITS = 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           region;
    logic [3:0]           qos;
  } axi4_metadata_type;

  typedef struct packed {
    logic                   aw_valid;
    axi4_metadata_type      aw_bits;
    logic [ID_BITS-1:0]     aw_id;
    logic [USER_BITS-1:0]   aw_user;
    logic                   w_valid;
    logic [DATA_BITS-1:0]   w_data;
    logic                   w_last;
    logic [DATA_BITS/8-1:0] w_strb;
    logic [USER_BITS-1:0]   w_user;
    logic                   b_ready;
    logic                   ar_valid;
    axi4_metadata_type      ar_bits;
    logic [ID_BITS-1:0]     ar_id;
    logic [USER_BITS-1:0]   ar_user;
    logic                   r_ready;
  } axi4_master_out_type;

  typedef struct packed {
    logic                 aw_ready;
    logic                 w_ready;
    logic                 b_valid;
    logic [1:0]           b_resp;
    logic [ID_BITS-1:0]   b_id;
    logic [USER_BITS-1:0] b_user;
    logic                 ar_ready;
    logic                 r_valid;
    logic [1:0]           r_resp;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_last;
    logic [ID_BITS-1:0]   r_id;
    logic [USER_BITS-1:0] r_user;
  } axi4_master_in_type;

  typedef axi4_master_out_type axi4_slave_in_type;
  typedef axi4_master_in_type  axi4_slave_out_type;

  localparam axi4_master_in_type axi4_master_in_none = '0;
  localparam axi4_slave_in_type  axi4_slave_in_none  = '0;
endpackage

module accel_axi_rrarb_ch #(
  parameter int NMST = 4,
  parameter int IDX  = 2
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic [NMST-1:0] req_i,
  input  logic [NMST-1:0] top_i,
  input  logic            hs_i,
  output logic            gnt_o,
  output logic [IDX-1:0]  idx_o
);
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} arb_st_e;

  arb_st_e        st_q, st_d;
  logic [IDX-1:0] idx_q, idx_d, ptr_q, ptr_d, rr_idx, win_idx;
  logic           upd_q, upd_d, rr_found, win_found;

  // Descending scan so the last hit is the first requester at or after ptr
  function automatic logic [IDX:0] pick(input logic [NMST-1:0] req, input logic [IDX-1:0] ptr);
    logic [IDX:0] res;
    int k;
    res = '0;
    for (int i = NMST - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NMST;
      if (req[k]) res = {1'b1, IDX'(k)};
    end
    return res;
  endfunction

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      st_q <= ST_IDLE; idx_q <= '0; ptr_q <= '0; upd_q <= 1'b0;
    end else begin
      st_q <= st_d; idx_q <= idx_d; ptr_q <= ptr_d; upd_q <= upd_d;
    end
  end

  // rr_ptr advances only when the grant was the plain round-robin choice
  always_comb begin
    {rr_found, rr_idx}   = pick(req_i, ptr_q);
    {win_found, win_idx} = pick(top_i, ptr_q);
    st_d = st_q; idx_d = idx_q; ptr_d = ptr_q; upd_d = upd_q;
    case (st_q)
      ST_IDLE: begin
        if (rr_found && win_found) begin
          st_d = ST_GRANT; idx_d = win_idx; upd_d = (win_idx == rr_idx);
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (hs_i) begin
          st_d  = ST_IDLE;
          ptr_d = upd_q ? IDX'((int'(idx_q) + 1) % NMST) : ptr_q;
        end else begin
          st_d = ST_GRANT;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign gnt_o = (st_q == ST_GRANT);
  assign idx_o = idx_q;
endmodule

module accel_axi_rrarb
  import accel_axi_rrarb_pkg::*;
#(
  parameter int NMST      = 4,
  parameter int WQ_DEPTH  = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  axi4_master_out_type i_xmsto [NMST],
  output axi4_master_in_type  o_xmsti [NMST],
  input  axi4_slave_out_type  i_xslvo,
  output axi4_slave_in_type   o_xslvi,
  output logic                o_busy
);
  localparam int IDX  = $clog2(NMST);
  localparam int CW   = $clog2(MAX_OUTST) + 1;
  localparam int QW   = $clog2(WQ_DEPTH);
  localparam int CNTW = QW + 1;

  logic               en_q;
  logic [CW-1:0]      rd_cnt_q [NMST], rd_cnt_d [NMST], wr_cnt_q [NMST], wr_cnt_d [NMST];
  logic [IDX-1:0]     wq_q [WQ_DEPTH];
  logic [QW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]    wq_cnt_q, wq_cnt_d;
  logic [NMST-1:0]    ar_req, aw_req, ar_top, aw_top, cnt_nz;
  logic               ar_gnt, aw_gnt, ar_hs, aw_hs, wq_full, wq_push, wq_pop;
  logic [IDX-1:0]     ar_idx, aw_idx, head, r_tgt, b_tgt;
  axi4_slave_in_type  xslvi;
  axi4_master_in_type xmsti [NMST];

  assign wq_full = (wq_cnt_q == CNTW'(WQ_DEPTH));
  assign head    = wq_q[rd_ptr_q];

  // Eligibility; with QoS enabled only the highest-qos eligible requesters compete
  always_comb begin
    for (int m = 0; m < NMST; m++) begin
      ar_req[m] = en_q && i_xmsto[m].ar_valid && (rd_cnt_q[m] < CW'(MAX_OUTST));
      aw_req[m] = en_q && i_xmsto[m].aw_valid && (wr_cnt_q[m] < CW'(MAX_OUTST)) && !wq_full;
    end
    ar_top = ar_req;
    aw_top = aw_req;
`ifdef ACCEL_AXI_RRARB_QOS_EN
    begin
      logic [3:0] ar_qm, aw_qm;
      ar_qm = 4'd0;
      aw_qm = 4'd0;
      for (int m = 0; m < NMST; m++) begin
        if (ar_req[m] && (i_xmsto[m].ar_bits.qos > ar_qm)) ar_qm = i_xmsto[m].ar_bits.qos;
        else ar_qm = ar_qm;
        if (aw_req[m] && (i_xmsto[m].aw_bits.qos > aw_qm)) aw_qm = i_xmsto[m].aw_bits.qos;
        else aw_qm = aw_qm;
      end
      for (int m = 0; m < NMST; m++) begin
        ar_top[m] = ar_req[m] && (i_xmsto[m].ar_bits.qos == ar_qm);
        aw_top[m] = aw_req[m] && (i_xmsto[m].aw_bits.qos == aw_qm);
      end
    end
`endif
  end

  accel_axi_rrarb_ch #(.NMST(NMST), .IDX(IDX)) u_ar (
    .i_clk(i_clk), .i_nrst(i_nrst), .req_i(ar_req), .top_i(ar_top),
    .hs_i(ar_hs), .gnt_o(ar_gnt), .idx_o(ar_idx));
  accel_axi_rrarb_ch #(.NMST(NMST), .IDX(IDX)) u_aw (
    .i_clk(i_clk), .i_nrst(i_nrst), .req_i(aw_req), .top_i(aw_top),
    .hs_i(aw_hs), .gnt_o(aw_gnt), .idx_o(aw_idx));

  // Forward granted AR/AW, queue-head W; route R/B by the low ID bits
  always_comb begin
    xslvi = axi4_slave_in_none;
    for (int m = 0; m < NMST; m++) xmsti[m] = axi4_master_in_none;
    r_tgt = i_xslvo.r_id[IDX-1:0];
    b_tgt = i_xslvo.b_id[IDX-1:0];
    if (en_q) begin
      if (ar_gnt) begin
        xslvi.ar_valid = i_xmsto[ar_idx].ar_valid;
        xslvi.ar_bits  = i_xmsto[ar_idx].ar_bits;
        xslvi.ar_id    = {i_xmsto[ar_idx].ar_id[ID_BITS-IDX-1:0], ar_idx};
        xslvi.ar_user  = i_xmsto[ar_idx].ar_user;
        xmsti[ar_idx].ar_ready = i_xslvo.ar_ready;
      end else begin
        xslvi.ar_valid = 1'b0;
      end
      if (aw_gnt) begin
        xslvi.aw_valid = i_xmsto[aw_idx].aw_valid;
        xslvi.aw_bits  = i_xmsto[aw_idx].aw_bits;
        xslvi.aw_id    = {i_xmsto[aw_idx].aw_id[ID_BITS-IDX-1:0], aw_idx};
        xslvi.aw_user  = i_xmsto[aw_idx].aw_user;
        xmsti[aw_idx].aw_ready = i_xslvo.aw_ready;
      end else begin
        xslvi.aw_valid = 1'b0;
      end
      if (wq_cnt_q != '0) begin
        xslvi.w_valid = i_xmsto[head].w_valid;
        xslvi.w_data  = i_xmsto[head].w_data;
        xslvi.w_last  = i_xmsto[head].w_last;
        xslvi.w_strb  = i_xmsto[head].w_strb;
        xslvi.w_user  = i_xmsto[head].w_user;
        xmsti[head].w_ready = i_xslvo.w_ready;
      end else begin
        xslvi.w_valid = 1'b0;
      end
      if (int'(r_tgt) < NMST) begin
        xmsti[r_tgt].r_valid = i_xslvo.r_valid;
        xmsti[r_tgt].r_resp  = i_xslvo.r_resp;
        xmsti[r_tgt].r_data  = i_xslvo.r_data;
        xmsti[r_tgt].r_last  = i_xslvo.r_last;
        xmsti[r_tgt].r_id    = i_xslvo.r_id >> IDX;
        xmsti[r_tgt].r_user  = i_xslvo.r_user;
        xslvi.r_ready = i_xmsto[r_tgt].r_ready;
      end else begin
        xslvi.r_ready = 1'b1;
      end
      if (int'(b_tgt) < NMST) begin
        xmsti[b_tgt].b_valid = i_xslvo.b_valid;
        xmsti[b_tgt].b_resp  = i_xslvo.b_resp;
        xmsti[b_tgt].b_id    = i_xslvo.b_id >> IDX;
        xmsti[b_tgt].b_user  = i_xslvo.b_user;
        xslvi.b_ready = i_xmsto[b_tgt].b_ready;
      end else begin
        xslvi.b_ready = 1'b1;
      end
    end else begin
      xslvi = axi4_slave_in_none;
    end
  end

  assign ar_hs  = xslvi.ar_valid && i_xslvo.ar_ready;
  assign aw_hs  = xslvi.aw_valid && i_xslvo.aw_ready;
  assign wq_pop = xslvi.w_valid && i_xslvo.w_ready && xslvi.w_last;

  // Saturating outstanding counters; simultaneous inc and dec cancel
  always_comb begin
    for (int m = 0; m < NMST; m++) begin
      logic rd_inc, rd_dec, wr_inc, wr_dec;
      rd_inc = ar_hs && (int'(ar_idx) == m);
      rd_dec = xmsti[m].r_valid && i_xmsto[m].r_ready && xmsti[m].r_last;
      wr_inc = aw_hs && (int'(aw_idx) == m);
      wr_dec = xmsti[m].b_valid && i_xmsto[m].b_ready;
      if (rd_inc && !rd_dec && (rd_cnt_q[m] != CW'(MAX_OUTST))) rd_cnt_d[m] = rd_cnt_q[m] + CW'(1);
      else if (rd_dec && !rd_inc && (rd_cnt_q[m] != '0))        rd_cnt_d[m] = rd_cnt_q[m] - CW'(1);
      else                                                      rd_cnt_d[m] = rd_cnt_q[m];
      if (wr_inc && !wr_dec && (wr_cnt_q[m] != CW'(MAX_OUTST))) wr_cnt_d[m] = wr_cnt_q[m] + CW'(1);
      else if (wr_dec && !wr_inc && (wr_cnt_q[m] != '0))        wr_cnt_d[m] = wr_cnt_q[m] - CW'(1);
      else                                                      wr_cnt_d[m] = wr_cnt_q[m];
      cnt_nz[m] = (rd_cnt_q[m] != '0) || (wr_cnt_q[m] != '0);
    end
  end

  // W-order queue pointers; a pop frees the slot a same-cycle push may take
  always_comb begin
    wq_push  = aw_hs && (!wq_full || wq_pop);
    wr_ptr_d = wq_push ? wr_ptr_q + QW'(1) : wr_ptr_q;
    rd_ptr_d = wq_pop ? rd_ptr_q + QW'(1) : rd_ptr_q;
    wq_cnt_d = wq_cnt_q + CNTW'(wq_push) - CNTW'(wq_pop);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      en_q <= 1'b0; wr_ptr_q <= '0; rd_ptr_q <= '0; wq_cnt_q <= '0;
      for (int i = 0; i < WQ_DEPTH; i++) wq_q[i] <= '0;
      for (int m = 0; m < NMST; m++) begin
        rd_cnt_q[m] <= '0; wr_cnt_q[m] <= '0;
      end
    end else begin
      en_q <= 1'b1; wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; wq_cnt_q <= wq_cnt_d;
      if (wq_push) wq_q[wr_ptr_q] <= aw_idx;
      for (int m = 0; m < NMST; m++) begin
        rd_cnt_q[m] <= rd_cnt_d[m]; wr_cnt_q[m] <= wr_cnt_d[m];
      end
    end
  end

  assign o_xslvi = xslvi;
  assign o_xmsti = xmsti;
  assign o_busy  = ar_gnt || aw_gnt || (wq_cnt_q != '0) || (|cnt_nz);
endmodule

// File: tb/tb_accel_axi_rrarb.sv
// Directed scoreboard bench for accel_axi_rrarb (NMST=4, WQ_DEPTH=4, MAX_OUTST=8).
module tb_accel_axi_rrarb;
  import accel_axi_rrarb_pkg::*;
  localparam int NMST = 4;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  axi4_master_out_type mo [NMST];
  axi4_master_in_type  mi [NMST];
  axi4_slave_out_type  so;
  axi4_slave_in_type   si;
  logic                busy;
  int                  checks = 0;
  int                  errors = 0;
  logic [31:0]         exp_q [$];

  always #5 clk = ~clk;

  accel_axi_rrarb #(.NMST(4), .WQ_DEPTH(4), .MAX_OUTST(8)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_xmsto(mo), .o_xmsti(mi),
    .i_xslvo(so), .o_xslvi(si), .o_busy(busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < NMST; m++) mo[m] = '0;
    so = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, cyc, nw, hsm, awm;
    int beat [NMST];
    logic hs_ar, hs_aw, hs_w, ok;
    logic [31:0] e;

    clear_inputs();
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    ok = (si === axi4_slave_in_none);
    for (int m = 0; m < NMST; m++) ok = ok && (mi[m] === axi4_master_in_none);
    chk("reset_outputs_none", 32'(ok), 32'd1);

    // AR round robin between masters 0 and 2
    do_reset();
    mo[0].ar_valid = 1'b1; mo[0].ar_id = 6'd3; mo[0].ar_bits.addr = 32'h1000;
    mo[2].ar_valid = 1'b1; mo[2].ar_id = 6'd1; mo[2].ar_bits.addr = 32'h2000;
    so.ar_ready = 1'b1;
    exp_q = {32'h0c, 32'h06, 32'h0c, 32'h06};
    @(negedge clk);
    chk("ar_latency", 32'(si.ar_valid), 32'd0);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (si.ar_valid) begin
        e = exp_q.pop_front();
        chk("ar_id_order", 32'(si.ar_id), e);
        chk("ar_addr", si.ar_bits.addr, (e == 32'h0c) ? 32'h1000 : 32'h2000);
        chk("ar_ready_other", 32'(mi[e[1:0] ^ 2'd2].ar_ready), 32'd0);
      end
    end
    chk("ar_drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    mo[0].ar_valid = 1'b0; mo[2].ar_valid = 1'b0;
    so.r_valid = 1'b1; so.r_last = 1'b1; so.r_id = 6'h0c; mo[0].r_ready = 1'b1;
    @(negedge clk);
    chk("r_route_valid", 32'(mi[0].r_valid), 32'd1);
    chk("r_route_id", 32'(mi[0].r_id), 32'd3);
    chk("r_other_valid", 32'(mi[2].r_valid), 32'd0);
    chk("r_slave_ready", 32'(si.r_ready), 32'd1);

    // W ordering by AW grant order, then B routing
    do_reset();
    mo[1].aw_valid = 1'b1; mo[1].aw_id = 6'd2;
    mo[3].aw_valid = 1'b1; mo[3].aw_id = 6'd4;
    for (int m = 1; m < NMST; m += 2) begin
      mo[m].w_valid = 1'b1; mo[m].w_data = 64'(m * 16); mo[m].b_ready = 1'b1; beat[m] = 0;
    end
    so.aw_ready = 1'b1; so.w_ready = 1'b0;
    exp_q = {32'h10, 32'h11, 32'h12, 32'h13, 32'h30, 32'h31, 32'h32, 32'h33};
    @(negedge clk);
    chk("w_stall_pre_aw", 32'(si.w_valid), 32'd0);
    chk("w_ready_pre_aw", 32'(mi[1].w_ready), 32'd0);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      @(negedge clk);
      hs_w = si.w_valid && so.w_ready;
      hs_aw = si.aw_valid && so.aw_ready;
      awm = int'(si.aw_id[1:0]);
      hsm = -1;
      if (hs_w) begin
        e = exp_q.pop_front();
        chk("w_order", si.w_data[31:0], e);
        hsm = int'(e[7:4]);
        if (hsm == 1) chk("w_ready_m3_blocked", 32'(mi[3].w_ready), 32'd0);
        if (si.w_last) chk("w_last_beat", 32'(e[3:0]), 32'd3);
      end
      @(posedge clk); #1; cyc++;
      if (hs_aw) mo[awm].aw_valid = 1'b0;
      if (hsm >= 0) begin
        beat[hsm]++;
        if (beat[hsm] == 4) mo[hsm].w_valid = 1'b0;
        mo[hsm].w_data = 64'(hsm * 16 + beat[hsm]);
        mo[hsm].w_last = (beat[hsm] == 3);
      end
      so.w_ready = (cyc >= 3);
    end
    chk("w_drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("busy_wr_outstanding", 32'(busy), 32'd1);
    @(posedge clk); #1;
    so.w_ready = 1'b0; so.b_valid = 1'b1; so.b_id = 6'h15;
    @(negedge clk);
    chk("b_route_valid", 32'(mi[1].b_valid), 32'd1);
    chk("b_route_id", 32'(mi[1].b_id), 32'd5);
    chk("b_other0", 32'(mi[0].b_valid), 32'd0);
    chk("b_other3", 32'(mi[3].b_valid), 32'd0);
    chk("b_slave_ready", 32'(si.b_ready), 32'd1);
    @(posedge clk); #1 so.b_id = 6'h03;
    @(posedge clk); #1 so.b_valid = 1'b0;
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);

    // W queue full blocks the fifth AW until a w_last pops
    do_reset();
    mo[0].aw_valid = 1'b1; mo[0].w_last = 1'b1; mo[0].w_data = 64'h55;
    so.aw_ready = 1'b1; so.w_ready = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (si.aw_valid && so.aw_ready) n++;
    end
    chk("wq_full_aw_count", 32'(n), 32'd4);
    chk("wq_full_aw_ready", 32'(mi[0].aw_ready), 32'd0);
    @(posedge clk); #1 mo[0].w_valid = 1'b1;
    @(negedge clk);
    chk("wq_head_fwd", 32'(si.w_valid), 32'd1);
    @(posedge clk); #1 mo[0].w_valid = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (si.aw_valid && so.aw_ready) n++;
    end
    chk("wq_after_pop_aw", 32'(n), 32'd1);

    // Outstanding read cap
    do_reset();
    mo[0].ar_valid = 1'b1; so.ar_ready = 1'b1;
    n = 0;
    repeat (24) begin
      @(negedge clk);
      if (si.ar_valid && so.ar_ready) n++;
    end
    chk("rd_cap_count", 32'(n), 32'd8);
    chk("rd_cap_ready", 32'(mi[0].ar_ready), 32'd0);
    @(posedge clk); #1;
    so.r_valid = 1'b1; so.r_last = 1'b1; so.r_id = 6'h1c; mo[0].r_ready = 1'b1;
    @(negedge clk);
    chk("rd_cap_r_valid", 32'(mi[0].r_valid), 32'd1);
    chk("rd_cap_r_id", 32'(mi[0].r_id), 32'd7);
    @(posedge clk); #1 so.r_valid = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (si.ar_valid && so.ar_ready) n++;
    end
    chk("rd_cap_ninth_ar", 32'(n), 32'd1);

    // Asynchronous reset mid-burst
    do_reset();
    mo[1].ar_valid = 1'b1; mo[1].aw_valid = 1'b1; mo[1].w_valid = 1'b1; mo[1].w_data = 64'h10;
    so.ar_ready = 1'b1; so.aw_ready = 1'b1; so.w_ready = 1'b1;
    nw = 0; cyc = 0;
    while (nw < 2 && cyc < 20) begin
      @(negedge clk);
      hs_ar = si.ar_valid && so.ar_ready;
      hs_aw = si.aw_valid && so.aw_ready;
      hs_w  = si.w_valid && so.w_ready;
      @(posedge clk); #1; cyc++;
      if (hs_ar) mo[1].ar_valid = 1'b0;
      if (hs_aw) mo[1].aw_valid = 1'b0;
      if (hs_w) begin
        nw++; mo[1].w_data = mo[1].w_data + 64'd1;
      end
    end
    chk("pre_reset_beats", 32'(nw), 32'd2);
    #2 nrst = 1'b0;
    #1;
    chk("midrst_slave_none", 32'(si === axi4_slave_in_none), 32'd1);
    ok = 1'b1;
    for (int m = 0; m < NMST; m++) ok = ok && (mi[m] === axi4_master_in_none);
    chk("midrst_master_none", 32'(ok), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    clear_inputs();
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); #1;
    mo[0].ar_valid = 1'b1; mo[0].ar_id = 6'd1; mo[3].ar_valid = 1'b1; mo[3].ar_id = 6'd1;
    mo[0].aw_valid = 1'b1; mo[0].aw_id = 6'd1; mo[3].aw_valid = 1'b1; mo[3].aw_id = 6'd1;
    exp_q = {32'h04, 32'h04};
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 6) begin
      @(negedge clk); cyc++;
      if (si.ar_valid) chk("post_rst_ar_winner", 32'(si.ar_id), exp_q.pop_front());
      if (si.aw_valid && exp_q.size() > 0) chk("post_rst_aw_winner", 32'(si.aw_id), exp_q.pop_front());
    end
    chk("post_rst_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
